memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/mem_stage_pkg.sv | 15 +
 rtl/memory_access_if.sv | 28 ++
 rtl/memory_access_data_mem.sv | 19 +
 rtl/memory_access.sv | 79 +++++++
 tb/tb_memory_access.sv | 133 +++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;
    localparam int WAIT_CYCLES_DEF = 1;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] target;
        logic        rd;
        logic        wr;
        logic        br;
        logic        zero;
    } txn_t;
endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: execute-to-memory stage bus; master is the upstream stage, slave is memory_access.
interface memory_access_if;
    logic        valid_in;
    logic [31:0] ALU_result;
    logic [31:0] read_data_2;
    logic [31:0] branch_or_not_address;
    logic        zero;
    logic        ctrl_memRead;
    logic        ctrl_memWrite;
    logic        ctrl_branch;
    logic        stall;
    logic        valid_out;
    logic [31:0] mem_read_data;
    logic [31:0] ALU_result_out;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        misaligned;
    modport master (
        output valid_in, ALU_result, read_data_2, branch_or_not_address, zero,
               ctrl_memRead, ctrl_memWrite, ctrl_branch,
        input  stall, valid_out, mem_read_data, ALU_result_out, pc_src, branch_target, misaligned
    );
    modport slave (
        input  valid_in, ALU_result, read_data_2, branch_or_not_address, zero,
               ctrl_memRead, ctrl_memWrite, ctrl_branch,
        output stall, valid_out, mem_read_data, ALU_result_out, pc_src, branch_target, misaligned
    );
endinterface

// File: rtl/memory_access_data_mem.sv
// data_mem: synchronous single-port 32-bit RAM, read-before-write, contents never reset.
module data_mem #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/memory_access.sv
// memory_access: multi-cycle memory stage with IDLE/WAIT/DONE FSM and a wait-state counter.
// Optional MEM_ALIGN_CHECK_EN suppresses misaligned accesses and flags them.
module memory_access
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input logic           clk,
    input logic           reset,
    memory_access_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    txn_t             q, in_t, cur;
    logic             accept, mem_op, finish, cur_mem, mis, access, rd_q;
    logic [31:0]      rdata;
    always_comb begin
        in_t = '{addr: bus.ALU_result, wdata: bus.read_data_2, target: bus.branch_or_not_address,
                 rd: bus.ctrl_memRead, wr: bus.ctrl_memWrite, br: bus.ctrl_branch, zero: bus.zero};
        cur     = (state == IDLE) ? in_t : q;
        accept  = (state == IDLE) && bus.valid_in;
        mem_op  = in_t.rd || in_t.wr;
        cur_mem = cur.rd || cur.wr;
        finish  = (accept && (!mem_op || WAIT_CYCLES == 0)) || (state == WAIT && cnt == CNT_W'(1));
    end
`ifdef MEM_ALIGN_CHECK_EN
    assign mis = cur_mem && cur.addr[1:0] != 2'b00;
`else
    assign mis = 1'b0;
`endif
    // The single RAM access lands on the edge that enters DONE.
    assign access            = finish && cur_mem && !mis;
    assign bus.stall         = (state == WAIT) || (accept && mem_op);
    assign bus.mem_read_data = rd_q ? rdata : 32'h0;
    data_mem #(.DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .en   (access),
        .we   (cur.wr),
        .addr (cur.addr[AW+1:2]),
        .wdata(cur.wdata),
        .rdata(rdata)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            q                  <= '0;
            rd_q               <= 1'b0;
            bus.valid_out      <= 1'b0;
            bus.ALU_result_out <= '0;
            bus.pc_src         <= 1'b0;
            bus.branch_target  <= '0;
            bus.misaligned     <= 1'b0;
        end else begin
            bus.valid_out <= finish;
            rd_q          <= access && cur.rd && !cur.wr;
            if (finish) begin
                bus.ALU_result_out <= cur.addr;
                bus.pc_src         <= cur.br && cur.zero;
                bus.branch_target  <= cur.target;
                bus.misaligned     <= mis;
            end
            case (state)
                IDLE: if (accept) begin
                    q     <= in_t;
                    cnt   <= CNT_W'(WAIT_CYCLES);
                    state <= finish ? DONE : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vector table plus a reset-abort sequence for memory_access (DEPTH=256, WAIT_CYCLES=1).
module tb_memory_access;
    typedef struct {
        logic        rd, wr, br, zero;
        logic [31:0] addr, wdata, target, exp_rd;
        logic        exp_pc, exp_mis;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    memory_access_if bus();
    memory_access #(.DEPTH(256), .WAIT_CYCLES(1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int tests = 0;
    int fails = 0;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, wr, br, zero, input logic [31:0] addr, wdata, target,
                                exp_rd, input logic exp_pc, exp_mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.br = br; v.zero = zero;
        v.addr = addr; v.wdata = wdata; v.target = target;
        v.exp_rd = exp_rd; v.exp_pc = exp_pc; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic vin);
        bus.valid_in              = vin;
        bus.ALU_result            = v.addr;
        bus.read_data_2           = v.wdata;
        bus.branch_or_not_address = v.target;
        bus.zero                  = v.zero;
        bus.ctrl_memRead          = v.rd;
        bus.ctrl_memWrite         = v.wr;
        bus.ctrl_branch           = v.br;
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int   lat = 0;
        int   stalls;
        logic done = 1'b0;
        logic mem = v.rd || v.wr;
        vec_t junk;
        @(negedge clk);
        drive(v, 1'b1);
        #1 stalls = int'(bus.stall);
        junk = mk(~v.rd, ~v.wr, ~v.br, ~v.zero, ~v.addr, ~v.wdata, ~v.target, 0, 0, 0);
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            lat++;
            done = bus.valid_out;
            if (!done) stalls += int'(bus.stall);
            if (i == 0) drive(junk, 1'b0);
        end
        check({tag, " latency"}, 32'(lat), mem ? 32'd2 : 32'd1);
        check({tag, " stall cycles"}, 32'(stalls), mem ? 32'd2 : 32'd0);
        check({tag, " mem_read_data"}, bus.mem_read_data, v.exp_rd);
        check({tag, " ALU_result_out"}, bus.ALU_result_out, v.addr);
        check({tag, " pc_src"}, 32'(bus.pc_src), 32'(v.exp_pc));
        check({tag, " branch_target"}, bus.branch_target, v.target);
        check({tag, " misaligned"}, 32'(bus.misaligned), 32'(v.exp_mis));
        @(posedge clk);
    endtask

    initial begin
        vecs[0]  = mk(0, 1, 0, 0, 32'h10,   32'hDEADBEEF, 32'h0,  32'h0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h10,   32'h0,        32'h0,  32'hDEADBEEF, 0, 0);
        vecs[2]  = mk(0, 0, 1, 1, 32'h1234, 32'h0,        32'h40, 32'h0, 1, 0);
        vecs[3]  = mk(0, 0, 1, 0, 32'h5678, 32'h0,        32'h80, 32'h0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 32'h9ABC, 32'h0,        32'h99, 32'h0, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 32'h400,  32'h5,        32'h0,  32'h0, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 32'h0,    32'h0,        32'h0,  32'h5, 0, 0);
        vecs[7]  = mk(1, 1, 0, 0, 32'h8,    32'h77,       32'h0,  32'h0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 0, 32'h8,    32'h0,        32'h0,  32'h77, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
        vecs[9]  = mk(1, 0, 0, 0, 32'h13,   32'h0,        32'h0,  32'h0, 0, 1);
`else
        vecs[9]  = mk(1, 0, 0, 0, 32'h13,   32'h0,        32'h0,  32'hDEADBEEF, 0, 0);
`endif
        vecs[10] = mk(0, 1, 0, 0, 32'h20,   32'hA5A5A5A5, 32'h0,  32'h0, 0, 0);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        repeat (2) @(negedge clk);
        check("reset valid_out", 32'(bus.valid_out), 32'h0);
        check("reset mem_read_data", bus.mem_read_data, 32'h0);
        check("reset ALU_result_out", bus.ALU_result_out, 32'h0);
        check("reset pc_src", 32'(bus.pc_src), 32'h0);
        check("reset branch_target", bus.branch_target, 32'h0);
        check("reset misaligned", 32'(bus.misaligned), 32'h0);
        check("reset stall", 32'(bus.stall), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) do_op(vecs[i], $sformatf("vec%0d", i));

        // Store aborted by reset during WAIT must leave the earlier 0xA5A5A5A5 in place.
        @(negedge clk);
        drive(mk(0, 1, 1, 1, 32'h20, 32'hFFFFFFFF, 32'h44, 0, 0, 0), 1'b1);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        check("abort in WAIT stall", 32'(bus.stall), 32'h1);
        reset = 1'b1;
        #1;
        check("abort stall", 32'(bus.stall), 32'h0);
        check("abort valid_out", 32'(bus.valid_out), 32'h0);
        check("abort ALU_result_out", bus.ALU_result_out, 32'h0);
        check("abort pc_src", 32'(bus.pc_src), 32'h0);
        check("abort branch_target", bus.branch_target, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                seen += int'(bus.valid_out);
            end
            check("abort no late valid_out", 32'(seen), 32'h0);
        end
        do_op(mk(1, 0, 0, 0, 32'h20, 0, 0, 32'hA5A5A5A5, 0, 0), "post-abort load");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
